// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, registered in_ready and synchronous flush.
// Optional stall cycle counter is enabled by defining PIPE_STAGE_STALL_CNT_EN.
//
//   state | meaning
//   EMPTY | no entries held; main shows its last or flushed value
//   ONE   | main holds the head entry
//   TWO   | main holds the head entry and skid holds the next one; input stalled
module pipe_stage_elastic #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_fire, out_fire;

  // Handshake outputs decode registered state only, so no ready path crosses the stage.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != TWO);
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = FLUSH_VAL;
      skid_nxt  = FLUSH_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Survives flush on purpose: it measures downstream back-pressure over the whole run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline register, the next generation of the fixed 2x32-bit IF/ID stage register.
- Carries an arbitrary-width payload between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake and a 2-entry skid buffer, so in_ready is a registered signal and no combinational ready path crosses stages.
- Supports synchronous flush (bubble insertion) that loads a programmable NOP value.

Parameters:
- DATA_W, 64, payload width in bits (e.g. PC+4 concatenated with instruction = 64).
- FLUSH_VAL, {DATA_W{1'b0}}, value loaded into both payload registers on reset or flush (NOP encoding).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous kill of all held and incoming data, active-high.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to downstream; driven directly from the main register.
- occupancy  out  2  number of entries held (0..2).

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- State encodes occupancy:
  - EMPTY = 0, ONE = 1, TWO = 2.
  - Value 3 is illegal and is never reached.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO). Both are decoded from registered state only.
- Reset (rst = 0, async):
  - state = EMPTY, main = skid = FLUSH_VAL.
  - out_valid = 0, in_ready = 1, occupancy = 0.
- Priority: reset > flush > normal transitions.
- Flush (flush = 1 at clock edge):
  - state <= EMPTY, main <= FLUSH_VAL, skid <= FLUSH_VAL.
  - Any in_fire in the same cycle is discarded.
  - Any out_fire in the same cycle is still considered consumed downstream; the block takes no further action for it.
- EMPTY:
  - in_fire -> ONE, main <= in_data.
  - Otherwise hold.
- ONE:
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire & !out_fire -> TWO, skid <= in_data; main unchanged.
  - !in_fire & out_fire -> EMPTY; main retains its last value (no toggling).
  - Neither -> hold.
- TWO:
  - in_ready = 0, so no in_fire is possible.
  - out_fire -> ONE, main <= skid.
  - Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid with the data visible on out_data.
- Throughput: 1 transfer/cycle sustained while out_ready = 1.
- Ordering: strict FIFO; no payload is ever dropped or duplicated except by flush.
- Held data is stable: while out_valid = 1 and out_ready = 0, out_data must not change.
- in_ready deasserts the cycle after the block enters TWO, never combinationally from out_ready.
- in_data is ignored whenever in_fire = 0.
- Reset mid-transfer: all entries are lost and the outputs take their reset values immediately (asynchronous).

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with out_valid = 1 and out_ready = 0.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then stream A = 64'h1, B = 64'h2, C = 64'h3 with in_valid = 1 and out_ready = 1 → out_data shows 1, 2, 3 on consecutive cycles, each one cycle after acceptance; occupancy stays 1; in_ready stays 1.
- Fill with out_ready = 0: accept A, then B → occupancy = 2 and in_ready = 0 on the next cycle. Raise out_ready → A then B emerge in order; in_ready returns to 1 the cycle after the first out_fire.
- Occupancy 2 holding A and B, assert flush together with in_valid (data C) → next cycle out_valid = 0, out_data = FLUSH_VAL, occupancy = 0; C never appears.
- Assert rst low mid-stream with occupancy 2 → out_valid = 0, in_ready = 1, out_data = FLUSH_VAL immediately, without waiting for a clock edge.
- Randomised valid/ready over 10k cycles with a scoreboard → output sequence equals input sequence; out_data is stable whenever out_valid & !out_ready.
- With PIPE_STAGE_STALL_CNT_EN: hold out_ready = 0 for 5 cycles with occupancy ≥ 1 → stall_cnt = 5; a following flush leaves it at 5.
